// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame length, retry limit.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_BITS,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } ps2_state_e;

  localparam int FRAME_LEN = 11;
`ifdef PS2_TX_RETRY_EN
  localparam int RETRY_LIMIT = 2;
`endif

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronizers plus FILTER_LEN glitch filters on both
// lines, with a one-cycle falling-edge pulse on the filtered clock.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_level_o,
  output logic clk_fall_o,
  output logic data_level_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  // index 0 = clock line, index 1 = data line
  logic [1:0]         raw;
  logic [1:0][1:0]    sync_q;
  logic [1:0]         level_q;
  logic [1:0][CW-1:0] cnt_q;
  logic [1:0]         flip;

  assign raw = {ps2_data_i, ps2_clk_i};

  // A new level is accepted on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    for (int i = 0; i < 2; i++)
      flip[i] = (sync_q[i][1] != level_q[i]) && (cnt_q[i] == CW'(FILTER_LEN - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      level_q <= '1;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][0], raw[i]};
        if (sync_q[i][1] == level_q[i] || flip[i]) cnt_q[i] <= '0;
        else                                       cnt_q[i] <= cnt_q[i] + 1'b1;
        if (flip[i]) level_q[i] <= sync_q[i][1];
      end
    end
  end

  assign clk_level_o  = level_q[0];
  assign data_level_o = level_q[1];
  assign clk_fall_o   = flip[0] & level_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ACK.
// Define PS2_TX_RETRY_EN to retry a failed frame up to RETRY_LIMIT times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2600,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ERROR,
  output logic       RX_INHIBIT,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    frame_q, frame_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          data_oe_q, data_oe_d;
  logic          done, fail, err;
  logic          clk_level, clk_fall, data_level;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retry_q, retry_d;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .ps2_clk_i    (PS2_CLK_IN),
    .ps2_data_i   (PS2_DATA_IN),
    .clk_level_o  (clk_level),
    .clk_fall_o   (clk_fall),
    .data_level_o (data_level)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    data_oe_d = data_oe_q;
    done      = 1'b0;
    fail      = 1'b0;
    err       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    // cnt doubles as the inhibit timer and the device-edge watchdog
    if (state_q inside {S_RTS, S_BITS, S_STOP, S_ACK, S_WAIT_IDLE}) begin
      cnt_d = clk_fall ? '0 : cnt_q + 1'b1;
      fail  = !clk_fall && (cnt_q == CW'(TIMEOUT_CYCLES));
    end
    case (state_q)
      S_IDLE: if (TX_VALID) begin
        frame_d   = {odd_parity(TX_DATA), TX_DATA};
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
        retry_d   = '0;
`endif
      end
      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // first device fall sets up bit0; falls 2..9 carry bits 1..7 and parity
      S_RTS, S_BITS: if (clk_fall) begin
        data_oe_d = ~frame_q[bit_cnt_q];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (state_q == S_RTS)                      state_d = S_BITS;
        else if (bit_cnt_q == 4'(FRAME_LEN - 3))   state_d = S_STOP;
      end
      S_STOP: if (clk_fall) begin
        data_oe_d = 1'b0;
        bit_cnt_d = 4'(FRAME_LEN - 1);
        state_d   = S_ACK;
      end
      S_ACK: if (clk_fall) begin
        bit_cnt_d = 4'(FRAME_LEN);
        if (data_level) fail = 1'b1;
        else            state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: if (clk_level && data_level) begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (done) fail = 1'b0;
    if (fail) begin
      data_oe_d = 1'b0;
      cnt_d     = '0;
      bit_cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'(RETRY_LIMIT)) begin
        retry_d = retry_q + 1'b1;
        state_d = S_INHIBIT;
      end else begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
`else
      err     = 1'b1;
      state_d = S_IDLE;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      data_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      data_oe_q <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign TX_READY    = (state_q == S_IDLE);
  assign RX_INHIBIT  = (state_q != S_IDLE);
  assign TX_DONE     = done;
  assign TX_ERROR    = err;
  assign PS2_CLK_OE  = (state_q == S_INHIBIT);
  assign PS2_DATA_OE = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the open-drain pair, scoreboard of expected outcomes.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int NTRY = 3;
`else
  localparam int NTRY = 1;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY, TX_DONE, TX_ERROR, RX_INHIBIT, PS2_CLK_OE, PS2_DATA_OE;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~PS2_CLK_OE;
  assign ps2_data_line = dev_data & ~PS2_DATA_OE;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .CLK(CLK), .RESET(RESET), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .TX_DONE(TX_DONE), .TX_ERROR(TX_ERROR), .RX_INHIBIT(RX_INHIBIT),
    .PS2_CLK_IN(ps2_clk_line), .PS2_DATA_IN(ps2_data_line),
    .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed { logic err; logic [9:0] frame; } exp_t;
  exp_t sb_q[$];

  int         n_chk = 0, n_fail = 0;
  logic [9:0] cap_frame = '0;
  int         inh_run = 0, inh_phases = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every DONE/ERROR pulse pops one expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge CLK);
      if (TX_DONE || TX_ERROR) begin
        check("done_err_exclusive", 32'(TX_DONE & TX_ERROR), 0);
        check("rx_inhibit_at_pulse", 32'(RX_INHIBIT), 1);
        check("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("outcome_err", 32'(TX_ERROR), 32'(e.err));
          if (!e.err) check("frame_bits", 32'(cap_frame), 32'(e.frame));
        end
        @(negedge CLK);
        check("ready_after_pulse", 32'(TX_READY), 1);
        check("rx_inhibit_after_pulse", 32'(RX_INHIBIT), 0);
      end
    end
  end

  // Inhibit phase length and RTS handoff.
  initial begin : inh_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        inh_run = 0;
        prev    = 1'b0;
      end else begin
        if (PS2_CLK_OE && !prev) begin inh_phases++; inh_run = 0; end
        if (PS2_CLK_OE) inh_run++;
        if (!PS2_CLK_OE && prev) begin
          check("inhibit_len", inh_run, INH);
          check("rts_data_oe", 32'(PS2_DATA_OE), 1);
        end
        prev = PS2_CLK_OE;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge CLK);
    while (!TX_READY && w < 5000) begin @(negedge CLK); w++; end
    TX_DATA  = b;
    TX_VALID = 1'b1;
    @(negedge CLK);
    TX_VALID = 1'b0;
    check("ready_dropped", 32'(TX_READY), 0);
  endtask

  // Keyboard model: waits for RTS, clocks 11 falls, records what it reads after falls 1..10.
  task automatic device_frame(input bit ack, input int abort_fall);
    int w;
    w = 0;
    while (!(ps2_data_line == 1'b0 && PS2_CLK_OE == 1'b0) && w < 3000) begin
      @(negedge CLK); w++;
    end
    if (w >= 3000) begin
      check("rts_seen", 32'(ps2_data_line), 0);
      return;
    end
    repeat (HALF) @(posedge CLK);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      repeat (HALF) @(posedge CLK);
      dev_clk = 1'b0;
      repeat (HALF - 1) @(posedge CLK);
      if (k == abort_fall) return;
      @(negedge CLK);
      if (k <= 10) cap_frame[k-1] = ps2_data_line;
      @(posedge CLK);
      dev_clk = 1'b1;
    end
    repeat (HALF) @(posedge CLK);
    dev_data = 1'b1;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 20000) begin @(negedge CLK); w++; end
    check("sb_drained", sb_q.size(), 0);
    repeat (3) @(negedge CLK);
  endtask

  logic [7:0] vec_d[3]  = '{8'hED, 8'h01, 8'hFF};
  logic [9:0] vec_f[3]  = '{10'h3ED, 10'h201, 10'h3FF}; // {stop, odd parity, data}

  initial begin
    int t0, w, p0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", 32'({TX_READY, TX_DONE, TX_ERROR, RX_INHIBIT, PS2_CLK_OE, PS2_DATA_OE}),
          32'(6'b100000));
    RESET = 1'b0;
    repeat (10) @(negedge CLK);

    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{1'b0, vec_f[i]});
      fork
        send(vec_d[i]);
        device_frame(1'b1, 0);
      join
      wait_drain();
    end

    // timeout: device never clocks
    sb_q.push_back('{1'b1, 10'h000});
    send(8'h55);
    w = 0; t0 = 0;
    for (int a = 0; a < NTRY; a++) begin
      while (!PS2_CLK_OE && w < 5000) begin @(negedge CLK); w++; end
      while (PS2_CLK_OE && w < 5000)  begin @(negedge CLK); w++; end
      t0 = cyc;
    end
    while (!TX_ERROR && w < 5000) begin @(negedge CLK); w++; end
    check("timeout_cycles", cyc - t0, TMO);
    @(negedge CLK);
    check("timeout_lines_released", 32'({PS2_CLK_OE, PS2_DATA_OE}), 0);
    wait_drain();

    // NACK at the 11th fall
    sb_q.push_back('{1'b1, 10'h000});
    p0 = inh_phases;
    fork
      send(8'hED);
      repeat (NTRY) device_frame(1'b0, 0);
    join
    wait_drain();
    check("nack_inhibit_phases", inh_phases - p0, NTRY);

    // async reset during the low phase after fall 5 (bit4 of 0x0F is 0 -> data driven low)
    fork
      send(8'h0F);
      device_frame(1'b1, 5);
    join
    check("pre_reset_data_oe", 32'(PS2_DATA_OE), 1);
    #2 RESET = 1'b1;
    #1;
    check("reset_async_oes", 32'({PS2_CLK_OE, PS2_DATA_OE}), 0);
    check("reset_async_ready", 32'(TX_READY), 1);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    check("reset_sb_empty", sb_q.size(), 0);

    sb_q.push_back('{1'b0, 10'h2F4});
    fork
      send(8'hF4);
      device_frame(1'b1, 0);
    join
    wait_drain();

    // TX_VALID with 0xAA mid-frame must be ignored
    sb_q.push_back('{1'b0, 10'h3FF});
    p0 = inh_phases;
    fork
      send(8'hFF);
      device_frame(1'b1, 0);
      begin
        repeat (300) @(negedge CLK);
        check("rx_inhibit_mid_frame", 32'(RX_INHIBIT), 1);
        TX_DATA  = 8'hAA;
        TX_VALID = 1'b1;
        @(negedge CLK);
        TX_VALID = 1'b0;
      end
    join
    wait_drain();
    repeat (50) @(negedge CLK);
    check("no_extra_frame", inh_phases - p0, 1);
    check("idle_after_ignored", 32'(TX_READY), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes (e.g. 0xED LED set, 0xFF reset) to the attached keyboard over the same open-drain PS2_CLK/PS2_DATA pair the keyboard receiver listens on. It runs the inhibit, request-to-send, 11-bit frame and ACK sequence, then hands the bus back. It asserts RX_INHIBIT so the receiver ignores host-driven traffic.

Parameters:
INHIBIT_CYCLES, 2600, CLK cycles the clock line is held low before request-to-send (≥100 µs at 25 MHz).
TIMEOUT_CYCLES, 375000, maximum CLK cycles between consecutive device falling edges (15 ms at 25 MHz).
FILTER_LEN, 4, consecutive equal synchronized samples needed to accept a new PS2_CLK level.

Ports:
CLK  in  1  system clock (PIXELCLK domain, ~25 MHz).
RESET  in  1  asynchronous, active-high reset.
TX_DATA  in  8  byte to send; sampled when TX_VALID & TX_READY.
TX_VALID  in  1  request to send TX_DATA.
TX_READY  out  1  high only in IDLE.
TX_DONE  out  1  one-cycle pulse: frame sent, ACK received.
TX_ERROR  out  1  one-cycle pulse: timeout or missing ACK.
RX_INHIBIT  out  1  high whenever not IDLE; the receiver discards bits while it is high.
PS2_CLK_IN  in  1  raw clock line level (asynchronous).
PS2_DATA_IN  in  1  raw data line level (asynchronous).
PS2_CLK_OE  out  1  1 = drive clock line low, 0 = release.
PS2_DATA_OE  out  1  1 = drive data line low, 0 = release.

Behaviour:
- Reset (async): state IDLE; TX_READY=1; all other outputs 0; counters and shift register cleared. Reset mid-frame releases both lines immediately.
- Inputs pass through a 2-FF synchronizer. PS2_CLK then goes through a FILTER_LEN glitch filter. A falling edge (fall) is a filtered 1→0 transition, one-cycle pulse.
- Handshake: accept on TX_VALID & TX_READY; latch byte; compute odd parity as ~^TX_DATA. TX_VALID outside IDLE is ignored.
- States:
  - IDLE: lines released.
  - INHIBIT: CLK_OE=1 for INHIBIT_CYCLES.
  - RTS: DATA_OE=1 (start bit 0), CLK_OE=0; timer cleared.
  - BITS: on each fall, put the next bit on the data line, where DATA_OE = ~bit. Order is bit0..bit7, then parity. Bit counter is 4 bits.
  - STOP: on the 10th fall, DATA_OE=0.
  - ACK: on the 11th fall, sample filtered data. 0 → WAIT_IDLE; 1 → error.
  - WAIT_IDLE: wait for both filtered lines high. Then pulse TX_DONE and go to IDLE.
- Timer: counts every cycle in RTS/BITS/STOP/ACK/WAIT_IDLE and is cleared on each fall. Reaching TIMEOUT_CYCLES gives an error.
- Error: release both lines, pulse TX_ERROR, go to IDLE. TX_DONE and TX_ERROR are never high together.
- The first fall after RTS is consumed by bit0 setup. Exactly 11 falls form a frame.
- TX_READY returns high in the cycle after TX_DONE or TX_ERROR.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on timeout or NACK, restart from INHIBIT with the same byte, up to 2 retries. TX_ERROR pulses only after the third failure. RX_INHIBIT stays high throughout.
- Undefined: the first failure pulses TX_ERROR; no retry counter is synthesized.

Decomposition:
- Package ps2_pkg: state encoding constants (IDLE, INHIBIT, RTS, BITS, STOP, ACK, WAIT_IDLE), frame length 11, retry limit 2.
- Sub-module ps2_line_filter: synchronizer, FILTER_LEN filter and fall detection. It is reusable by the keyboard receiver.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs → data line after falls 1–9 reads 1,0,1,1,0,1,1,1, parity 1. Line released at fall 10. One TX_DONE; TX_ERROR stays 0.
- Send 0x01 → parity 0. Send 0xFF → parity 1. Check CLK_OE held exactly INHIBIT_CYCLES before DATA_OE rises.
- Device never clocks after RTS → TX_ERROR exactly TIMEOUT_CYCLES after CLK_OE drops. Both OE=0; TX_READY=1 the next cycle.
- Device leaves data high at the 11th fall (NACK) → TX_ERROR; with PS2_TX_RETRY_EN, three INHIBIT phases occur before TX_ERROR.
- Assert RESET at fall 5 of a frame → OEs 0 asynchronously; TX_READY=1; no DONE or ERROR pulse. The next send of 0xF4 completes normally.
- Pulse TX_VALID with 0xAA while a frame is in progress → ignored. The frame in flight completes with its original byte; RX_INHIBIT stays high until TX_DONE.
